// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Purpose  : Instruction-fetch front end with one outstanding imem request and
//            a DEPTH-entry {pc, instr} queue feeding ID via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic                       imem_ready_i,
  input  logic                       imem_rvalid_i,
  input  logic [XLEN-1:0]            imem_rdata_i,
  output logic                       id_valid_o,
  output logic [XLEN-1:0]            id_instr_o,
  output logic [XLEN-1:0]            id_pc_o,
  input  logic                       id_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign imem_req_o   = (state_q == S_FETCH) && (count_q < DEPTH_C) && !redirect_valid_i && !rst;
  assign imem_addr_o  = fetch_pc_q;
  assign id_valid_o   = (count_q != '0) && !rst;
  assign id_instr_o   = id_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign id_pc_o      = id_valid_o ? pc_mem_q[rd_ptr_q] : '0;
  assign fifo_count_o = rst ? '0 : count_q;

  // A redirect squashes both the response landing this cycle and any pop.
  assign issue = imem_req_o && imem_ready_i;
  assign push  = (state_q == S_WAIT) && imem_rvalid_i && !redirect_valid_i && !rst;
  assign pop   = id_valid_o && id_ready_i && !redirect_valid_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (redirect_valid_i) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
      // An outstanding request still owes a response; drop it unless it lands now.
      if (state_q != S_FETCH) begin
        state_q <= imem_rvalid_i ? S_FETCH : S_DROP;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case (state_q)
        S_FETCH: begin
          if (issue) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + XLEN'(4);
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_q <= S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_rvalid_i) begin
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_queue
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] XMASK = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_prefetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ready_i     (imem_ready),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .id_valid_o       (id_valid),
    .id_instr_o       (id_instr),
    .id_pc_o          (id_pc),
    .id_ready_i       (id_ready),
    .fifo_count_o     (fifo_count)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        idr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_idpc;
    logic [31:0] e_inst;
    int          e_cnt;
  } vec_t;

  vec_t tbl [12];

  // Reference model state
  logic [63:0] mq [$];
  logic [31:0] m_fpc;
  logic [31:0] m_reqpc;
  logic        m_busy;
  logic        m_drop;

  // Random responder state
  logic        r_pend;
  logic [31:0] r_addr;
  int          r_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy,
                       input logic rv, input logic [31:0] rdata, input logic idr);
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    imem_rvalid    = rv;
    imem_rdata     = rdata;
    id_ready       = idr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_idv",   32'(id_valid), 32'd0);
    chk("rst_cnt",   32'(fifo_count), 32'd0);
    chk("rst_idpc",  id_pc, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    rst = 1'b0;
    imem_ready = 1'b0;
  endtask

  // Issue at the current fetch pc, then return a 1-cycle response.
  task automatic fetch_one(input logic [31:0] addr, input logic idr);
    drive(1'b0, '0, 1'b1, 1'b0, '0, idr);
    drive(1'b0, '0, 1'b0, 1'b1, addr ^ XMASK, idr);
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'(!m_busy && mq.size() < DEPTH && !redirect_valid));
    chk({tag, "_addr"},  imem_addr, m_fpc);
    chk({tag, "_idv"},   32'(id_valid), 32'(mq.size() != 0));
    chk({tag, "_idpc"},  id_pc, (mq.size() != 0) ? mq[0][63:32] : 32'd0);
    chk({tag, "_instr"}, id_instr, (mq.size() != 0) ? mq[0][31:0] : 32'd0);
    chk({tag, "_cnt"},   32'(fifo_count), 32'(mq.size()));
  endtask

  task automatic model_step();
    logic m_req;
    logic m_pop;
    m_req = !m_busy && mq.size() < DEPTH && !redirect_valid;
    m_pop = mq.size() != 0 && id_ready;
    if (redirect_valid) begin
      mq.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
      if (m_busy) begin
        if (imem_rvalid) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_busy && imem_rvalid) begin
        if (!m_drop) mq.push_back({m_reqpc, imem_rdata});
        m_busy = 1'b0;
        m_drop = 1'b0;
      end else if (m_req && imem_ready) begin
        m_reqpc = m_fpc;
        m_fpc   = m_fpc + 32'd4;
        m_busy  = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;

    // T1 reset, then the directed vector table (stream, redirect in FETCH/WAIT, drop)
    tbl[0]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,   1'b0, 32'h0, 32'h0,        0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h4,   1'b0, 32'h0, 32'h0,        0};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,   1'b1, 32'h0, 32'hA5A5A5A5, 1};
    tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hA5A5A5A1, 1'b1, 1'b0, 32'h8,   1'b0, 32'h0, 32'h0,        0};
    tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,   1'b1, 32'h4, 32'hA5A5A5A1, 1};
    tbl[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hA5A5A5AD, 1'b0, 1'b0, 32'hC,   1'b1, 32'h4, 32'hA5A5A5A1, 1};
    tbl[6]  = '{1'b1, 32'h103, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,   1'b1, 32'h4, 32'hA5A5A5A1, 2};
    tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0,        0};
    tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0,        0};
    tbl[9]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h104, 1'b0, 32'h0, 32'h0,        0};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 32'h0,        0};
    tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0,        0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].idr);
      chk($sformatf("vec%0d_req", i),   32'(imem_req),   32'(tbl[i].e_req));
      chk($sformatf("vec%0d_addr", i),  imem_addr,       tbl[i].e_addr);
      chk($sformatf("vec%0d_idv", i),   32'(id_valid),   32'(tbl[i].e_idv));
      chk($sformatf("vec%0d_idpc", i),  id_pc,           tbl[i].e_idpc);
      chk($sformatf("vec%0d_instr", i), id_instr,        tbl[i].e_inst);
      chk($sformatf("vec%0d_cnt", i),   32'(fifo_count), 32'(tbl[i].e_cnt));
    end

    // T3 backpressure: fill the queue, then free one slot
    do_reset();
    for (int i = 0; i < DEPTH; i++) fetch_one(32'(i * 4), 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("bp_full_cnt", 32'(fifo_count), 32'd4);
    chk("bp_full_req", 32'(imem_req), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("bp_pop_cnt",  32'(fifo_count), 32'd3);
    chk("bp_pop_req",  32'(imem_req), 32'd1);
    chk("bp_pop_addr", imem_addr, 32'h10);
    chk("bp_pop_head", id_pc, 32'h4);

    // T5 redirect + rvalid + pop in one cycle with two entries queued
    do_reset();
    fetch_one(32'h0, 1'b0);
    fetch_one(32'h4, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h8 ^ XMASK, 1'b1);
    chk("rdp_cnt_pre", 32'(fifo_count), 32'd2);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("rdp_cnt",  32'(fifo_count), 32'd0);
    chk("rdp_idv",  32'(id_valid), 32'd0);
    chk("rdp_req",  32'(imem_req), 32'd1);
    chk("rdp_addr", imem_addr, 32'h100);
    fetch_one(32'h100, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("rdp_head_pc",    id_pc, 32'h100);
    chk("rdp_head_instr", id_instr, 32'h100 ^ XMASK);

    // T6 alignment and address wrap
    drive(1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
    chk("wrap_req",  32'(imem_req), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 32'hFFFFFFFC ^ XMASK, 1'b0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("wrap_head_pc", id_pc, 32'hFFFFFFFC);
    chk("wrap_cnt",     32'(fifo_count), 32'd1);

    // Randomized traffic against the reference model
    do_reset();
    mq.delete();
    m_fpc = 32'h0; m_reqpc = 32'h0; m_busy = 1'b0; m_drop = 1'b0;
    r_pend = 1'b0; r_addr = '0; r_lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        redir;
      logic [31:0] rpc;
      logic        rv;
      logic [31:0] rdata;
      redir = ($urandom % 16) == 0;
      rpc   = $urandom;
      rv    = 1'b0;
      rdata = $urandom;
      if (r_pend && r_lat == 0) begin
        rv    = 1'b1;
        rdata = r_addr ^ XMASK;
      end else if (!r_pend && ($urandom % 20) == 0) begin
        rv = 1'b1;
      end
      drive(redir, rpc, ($urandom % 4) != 0, rv, rdata, ($urandom % 3) != 0);
      model_check("rnd");
      if (rv && r_pend) r_pend = 1'b0;
      if (imem_req && imem_ready) begin
        r_pend = 1'b1;
        r_addr = imem_addr;
        r_lat  = int'($urandom % 3);
      end else if (r_pend && r_lat > 0) begin
        r_lat--;
      end
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
